// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP+ACCESS per AHB NONSEQ/SEQ transfer.
// Define APB_BRIDGE_APB4_EN to add PSTRB/PPROT and allow sub-word writes.
module ahb_apb_bridge #(
    parameter int NUM_APB    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SLV_SHIFT  = 12
) (
    input  logic                          hclk_in,
    input  logic                          hreset_in,
    input  logic                          s_hsel_in,
    input  logic [ADDR_WIDTH-1:0]         s_haddr_in,
    input  logic                          s_hwrite_in,
    input  logic [1:0]                    s_htrans_in,
    input  logic [2:0]                    s_hsize_in,
    input  logic [3:0]                    s_hprot_in,
    input  logic [DATA_WIDTH-1:0]         s_hwdata_in,
    input  logic                          s_hready_in,
    output logic [DATA_WIDTH-1:0]         s_hrdata_out,
    output logic                          s_hreadyout_out,
    output logic                          s_hresp_out,
    output logic [ADDR_WIDTH-1:0]         p_paddr_out,
    output logic [NUM_APB-1:0]            p_psel_out,
    output logic                          p_penable_out,
    output logic                          p_pwrite_out,
    output logic [DATA_WIDTH-1:0]         p_pwdata_out,
`ifdef APB_BRIDGE_APB4_EN
    output logic [3:0]                    p_pstrb_out,
    output logic [2:0]                    p_pprot_out,
`endif
    input  logic [NUM_APB*DATA_WIDTH-1:0] p_prdata_in,
    input  logic [NUM_APB-1:0]            p_pready_in,
    input  logic [NUM_APB-1:0]            p_pslverr_in
);

    // state  | meaning
    // IDLE   | no transfer in flight, HREADYOUT high, accepts address phase
    // SETUP  | APB setup phase, PSEL high, PENABLE low
    // ACCESS | APB access phase, waits for PREADY of the selected peripheral
    // ERR1   | first ERROR cycle, HREADYOUT low
    // ERR2   | second ERROR cycle, HREADYOUT high, accepts address phase
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam int IDX_W = (NUM_APB > 1) ? $clog2(NUM_APB) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   addr_idx;
    logic [NUM_APB-1:0] dec_sel;
    logic               in_range;
    logic               size_ok;
    logic               capture;
    logic               req_err;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    generate
        if (NUM_APB > 1) begin : g_idx
            assign addr_idx = s_haddr_in[SLV_SHIFT +: IDX_W];
        end else begin : g_idx_single
            assign addr_idx = '0;
        end
    endgenerate

    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NUM_APB; i++) begin
            dec_sel[i] = (addr_idx == IDX_W'(i));
        end
    end

    // A non-power-of-two NUM_APB leaves index codes with no peripheral behind them.
    assign in_range = |dec_sel;

`ifdef APB_BRIDGE_APB4_EN
    logic [3:0] wr_strb;
    logic       unused_bits;

    always_comb begin
        wr_strb = 4'b0000;
        if (s_hwrite_in) begin
            case (s_hsize_in)
                3'b000:  wr_strb = 4'b0001 << s_haddr_in[1:0];
                3'b001:  wr_strb = 4'b0011 << s_haddr_in[1:0];
                default: wr_strb = 4'b1111;
            endcase
        end
    end

    assign size_ok     = 1'b1;
    assign unused_bits = ^{s_htrans_in[0], s_hprot_in[3:2]};
`else
    logic unused_bits;

    // Without byte strobes a narrow write would clobber the whole word.
    assign size_ok     = !s_hwrite_in || (s_hsize_in == 3'b010);
    assign unused_bits = ^{s_htrans_in[0], s_hprot_in};
`endif

    assign capture = s_hsel_in && s_hready_in && s_htrans_in[1] &&
                     ((state == ST_IDLE) || (state == ST_ERR2));
    assign req_err = !in_range || !size_ok;

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_APB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = p_pready_in[i];
                sel_err   = p_pslverr_in[i];
                sel_rdata = p_prdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // HWDATA is only valid in the data phase, which spans SETUP and ACCESS.
    assign p_pwdata_out = ((state == ST_SETUP) || (state == ST_ACCESS)) ? s_hwdata_in : '0;

    always_ff @(posedge hclk_in) begin
        if (hreset_in) begin
            state           <= ST_IDLE;
            idx_q           <= '0;
            p_psel_out      <= '0;
            p_penable_out   <= 1'b0;
            p_pwrite_out    <= 1'b0;
            p_paddr_out     <= '0;
            s_hreadyout_out <= 1'b1;
            s_hresp_out     <= 1'b0;
            s_hrdata_out    <= '0;
`ifdef APB_BRIDGE_APB4_EN
            p_pstrb_out     <= 4'b0000;
            p_pprot_out     <= 3'b000;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (capture && req_err) begin
                        state           <= ST_ERR1;
                        s_hreadyout_out <= 1'b0;
                        s_hresp_out     <= 1'b1;
                    end else if (capture) begin
                        state           <= ST_SETUP;
                        idx_q           <= addr_idx;
                        p_psel_out      <= dec_sel;
                        p_penable_out   <= 1'b0;
                        p_pwrite_out    <= s_hwrite_in;
                        p_paddr_out     <= s_haddr_in;
                        s_hreadyout_out <= 1'b0;
                        s_hresp_out     <= 1'b0;
`ifdef APB_BRIDGE_APB4_EN
                        p_pstrb_out     <= wr_strb;
                        p_pprot_out     <= {~s_hprot_in[0], 1'b0, s_hprot_in[1]};
`endif
                    end else begin
                        state           <= ST_IDLE;
                        s_hreadyout_out <= 1'b1;
                        s_hresp_out     <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state         <= ST_ACCESS;
                    p_penable_out <= 1'b1;
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        p_psel_out    <= '0;
                        p_penable_out <= 1'b0;
                        if (sel_err) begin
                            state       <= ST_ERR1;
                            s_hresp_out <= 1'b1;
                        end else begin
                            state           <= ST_IDLE;
                            s_hreadyout_out <= 1'b1;
                            if (!p_pwrite_out) begin
                                s_hrdata_out <= sel_rdata;
                            end
                        end
                    end
                end
                ST_ERR1: begin
                    state           <= ST_ERR2;
                    s_hreadyout_out <= 1'b1;
                    s_hresp_out     <= 1'b1;
                end
                default: begin
                    state           <= ST_IDLE;
                    p_psel_out      <= '0;
                    p_penable_out   <= 1'b0;
                    s_hreadyout_out <= 1'b1;
                    s_hresp_out     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Randomized bench for ahb_apb_bridge with three APB slaves (index 3 is an undecoded window).
// Build with APB_BRIDGE_APB4_EN to exercise the strobe/protection outputs.
module tb_ahb_apb_bridge;

    localparam int NUM_APB = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;

    logic                  hclk_in = 1'b0;
    logic                  hreset_in;
    logic                  s_hsel_in;
    logic [AW-1:0]         s_haddr_in;
    logic                  s_hwrite_in;
    logic [1:0]            s_htrans_in;
    logic [2:0]            s_hsize_in;
    logic [3:0]            s_hprot_in;
    logic [DW-1:0]         s_hwdata_in;
    logic                  s_hready_in;
    logic [DW-1:0]         s_hrdata_out;
    logic                  s_hreadyout_out;
    logic                  s_hresp_out;
    logic [AW-1:0]         p_paddr_out;
    logic [NUM_APB-1:0]    p_psel_out;
    logic                  p_penable_out;
    logic                  p_pwrite_out;
    logic [DW-1:0]         p_pwdata_out;
`ifdef APB_BRIDGE_APB4_EN
    logic [3:0]            p_pstrb_out;
    logic [2:0]            p_pprot_out;
`endif
    logic [NUM_APB*DW-1:0] p_prdata_in;
    logic [NUM_APB-1:0]    p_pready_in;
    logic [NUM_APB-1:0]    p_pslverr_in;
    logic                  hready_block;

    always #5 hclk_in = ~hclk_in;

    // The matrix feeds this slave's own HREADYOUT back as the bus HREADY.
    assign s_hready_in = s_hreadyout_out & ~hready_block;

    ahb_apb_bridge #(
        .NUM_APB   (NUM_APB),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SLV_SHIFT (12)
    ) dut (
        .hclk_in        (hclk_in),
        .hreset_in      (hreset_in),
        .s_hsel_in      (s_hsel_in),
        .s_haddr_in     (s_haddr_in),
        .s_hwrite_in    (s_hwrite_in),
        .s_htrans_in    (s_htrans_in),
        .s_hsize_in     (s_hsize_in),
        .s_hprot_in     (s_hprot_in),
        .s_hwdata_in    (s_hwdata_in),
        .s_hready_in    (s_hready_in),
        .s_hrdata_out   (s_hrdata_out),
        .s_hreadyout_out(s_hreadyout_out),
        .s_hresp_out    (s_hresp_out),
        .p_paddr_out    (p_paddr_out),
        .p_psel_out     (p_psel_out),
        .p_penable_out  (p_penable_out),
        .p_pwrite_out   (p_pwrite_out),
        .p_pwdata_out   (p_pwdata_out),
`ifdef APB_BRIDGE_APB4_EN
        .p_pstrb_out    (p_pstrb_out),
        .p_pprot_out    (p_pprot_out),
`endif
        .p_prdata_in    (p_prdata_in),
        .p_pready_in    (p_pready_in),
        .p_pslverr_in   (p_pslverr_in)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [4][16];   // reference view, updated from AHB intent
    logic [31:0] slv_mem [4][16];   // APB slave storage, updated from APB signals
    logic [31:0] last_rdata;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk_in);
        #1;
    endtask

    task automatic drive_idle();
        s_hsel_in   = 1'b0;
        s_htrans_in = 2'b00;
    endtask

    task automatic scramble_apb();
        p_pready_in  = NUM_APB'($urandom);
        p_pslverr_in = NUM_APB'($urandom);
        for (int i = 0; i < NUM_APB; i++) p_prdata_in[i*DW +: DW] = $urandom;
    endtask

    // One AHB transfer, started in a cycle where HREADYOUT is high; returns in its completion cycle.
    task automatic ahb_xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                            input logic [31:0] wdata, input int nwait, input bit slverr);
        int idx, exp_waits, c, acc_cnt, first_psel, first_pen, nbytes, base;
        bit exp_err, exp_resp, done, multi, resp_wait, got_acc;
        logic [3:0] exp_strb, hprot, a_pstrb;
        logic [2:0] a_pprot;
        logic [NUM_APB-1:0] psel_seen;
        logic [31:0] a_paddr, a_pwdata;
        logic a_pwrite;
        idx = int'(addr[13:12]);
        nbytes = 1 << size;
        base = int'(addr[1:0]) & ~(nbytes - 1);
        exp_strb = 4'b0000;
        for (int k = 0; k < 4; k++) if (wr && k >= base && k < base + nbytes) exp_strb[k] = 1'b1;
        exp_err = (idx >= NUM_APB);
`ifndef APB_BRIDGE_APB4_EN
        if (wr && size != 3'd2) exp_err = 1'b1;
`endif
        exp_waits = exp_err ? 1 : 2 + nwait + (slverr ? 1 : 0);
        exp_resp  = exp_err || slverr;
        hprot = 4'($urandom);
        {c, acc_cnt, first_psel, first_pen} = '0;
        {done, multi, resp_wait, got_acc} = '0;
        psel_seen = '0;
        {a_paddr, a_pwdata, a_pwrite, a_pstrb, a_pprot} = '0;

        s_hsel_in = 1'b1; s_htrans_in = 2'b10; s_haddr_in = addr;
        s_hwrite_in = wr; s_hsize_in = size; s_hprot_in = hprot;
        step();
        c = 1;
        drive_idle();
        s_hwdata_in = wdata;
        while (!done && c <= 40) begin
            scramble_apb();
            if (idx < NUM_APB) p_prdata_in[idx*DW +: DW] = slv_mem[idx][addr[5:2]];
            if (p_psel_out != '0 && first_psel == 0) first_psel = c;
            if (p_penable_out && first_pen == 0) first_pen = c;
            if ($countones(p_psel_out) > 1) multi = 1'b1;
            psel_seen |= p_psel_out;
            if (!exp_err && p_psel_out[idx] && p_penable_out) begin
                if (!got_acc) begin
                    a_paddr = p_paddr_out; a_pwrite = p_pwrite_out; a_pwdata = p_pwdata_out;
`ifdef APB_BRIDGE_APB4_EN
                    a_pstrb = p_pstrb_out; a_pprot = p_pprot_out;
`endif
                end
                got_acc = 1'b1;
                p_pready_in[idx]  = (acc_cnt == nwait);
                p_pslverr_in[idx] = slverr && (acc_cnt == nwait);
                if (acc_cnt == nwait && !slverr && p_pwrite_out) begin
                    for (int k = 0; k < 4; k++) begin
`ifdef APB_BRIDGE_APB4_EN
                        if (p_pstrb_out[k])
`endif
                        slv_mem[idx][addr[5:2]][k*8 +: 8] = p_pwdata_out[k*8 +: 8];
                    end
                end
                acc_cnt++;
            end
            if (s_hreadyout_out) begin
                done = 1'b1;
            end else begin
                resp_wait = s_hresp_out;
                step();
                c++;
            end
        end
        if (!done) begin
            chk_val("timeout", 0, 1);
            hreset_in = 1'b1; step(); hreset_in = 1'b0;
            last_rdata = '0;
            return;
        end
        chk_val("wait_states", c - 1, exp_waits);
        chk_val("hresp_final", s_hresp_out, exp_resp);
        chk_val("hresp_last_wait", resp_wait, exp_resp);
        chk_val("psel_at_done", p_psel_out, 0);
        chk_val("penable_at_done", p_penable_out, 0);
        chk_val("psel_onehot", multi, 0);
        if (exp_err) begin
            chk_val("psel_on_error", psel_seen, 0);
        end else begin
            chk_val("psel_index", psel_seen, 1 << idx);
            chk_val("psel_cycle", first_psel, 1);
            chk_val("penable_cycle", first_pen, 2);
            chk_val("paddr", a_paddr, addr);
            chk_val("pwrite", a_pwrite, wr);
            if (wr) chk_val("pwdata", a_pwdata, wdata);
`ifdef APB_BRIDGE_APB4_EN
            chk_val("pstrb", a_pstrb, exp_strb);
            chk_val("pprot", a_pprot, {~hprot[0], 1'b0, hprot[1]});
`endif
            if (!slverr) begin
                if (wr) begin
                    for (int k = 0; k < 4; k++)
                        if (exp_strb[k]) ref_mem[idx][addr[5:2]][k*8 +: 8] = wdata[k*8 +: 8];
                end else begin
                    last_rdata = ref_mem[idx][addr[5:2]];
                end
            end
        end
        chk_val("hrdata", s_hrdata_out, last_rdata);
    endtask

    task automatic idle_gap();
        drive_idle();
        step();
    endtask

    // Cycles that must not start a transfer: IDLE/BUSY, unselected, or bus HREADY low.
    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            s_haddr_in   = $urandom & 32'h0000_1FFC;
            s_hwrite_in  = 1'($urandom);
            s_hsize_in   = 3'd2;
            s_hsel_in    = (mode != 2);
            s_htrans_in  = (mode == 0) ? 2'b00 : (mode == 1) ? 2'b01 : 2'b10;
            hready_block = (mode == 3);
            step();
            chk_val("noise_hreadyout", s_hreadyout_out, 1);
            chk_val("noise_psel", p_psel_out, 0);
        end
        hready_block = 1'b0;
        drive_idle();
        step();
    endtask

    initial begin
        logic [31:0] addr;
        bit wr, prev_ok;
        logic [2:0] size;

        hready_block = 1'b0;
        hreset_in = 1'b1;
        drive_idle();
        s_haddr_in = '0; s_hwrite_in = 1'b0; s_hsize_in = 3'd2; s_hprot_in = '0; s_hwdata_in = '0;
        p_prdata_in = '0; p_pready_in = '0; p_pslverr_in = '0;
        last_rdata = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) begin
                ref_mem[i][j] = $urandom;
                slv_mem[i][j] = ref_mem[i][j];
            end
        ref_mem[2][0] = 32'h1234_5678;
        slv_mem[2][0] = 32'h1234_5678;

        repeat (3) step();
        chk_val("rst_psel", p_psel_out, 0);
        chk_val("rst_penable", p_penable_out, 0);
        chk_val("rst_pwrite", p_pwrite_out, 0);
        chk_val("rst_paddr", p_paddr_out, 0);
        chk_val("rst_hreadyout", s_hreadyout_out, 1);
        chk_val("rst_hresp", s_hresp_out, 0);
        chk_val("rst_hrdata", s_hrdata_out, 0);
        hreset_in = 1'b0;
        step();

        ahb_xfer(32'h0000_1004, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0); idle_gap();
        ahb_xfer(32'h0000_2000, 1'b0, 3'd2, 32'h0, 3, 1'b0);         idle_gap();
        ahb_xfer(32'h0000_0010, 1'b1, 3'd2, 32'hCAFE_F00D, 1, 1'b0 | 1'b1); idle_gap();
        ahb_xfer(32'h0000_3000, 1'b0, 3'd2, 32'h0, 0, 1'b0);         idle_gap();
        ahb_xfer(32'h0000_1004, 1'b0, 3'd2, 32'h0, 0, 1'b0);
        ahb_xfer(32'h0000_0008, 1'b0, 3'd2, 32'h0, 0, 1'b0);         idle_gap();
        ahb_xfer(32'h0000_1003, 1'b1, 3'd0, 32'hA5A5_A5A5, 0, 1'b0); idle_gap();
        ahb_xfer(32'h0000_1004, 1'b0, 3'd2, 32'h0, 0, 1'b0);         idle_gap();
        noise(12);

        // Reset while the bridge sits in ACCESS with PREADY low.
        s_hsel_in = 1'b1; s_htrans_in = 2'b10; s_haddr_in = 32'h0000_1008;
        s_hwrite_in = 1'b0; s_hsize_in = 3'd2;
        step();
        drive_idle();
        p_pready_in = '0;
        step();
        p_pready_in = '0;
        hreset_in = 1'b1;
        step();
        chk_val("midrst_psel", p_psel_out, 0);
        chk_val("midrst_penable", p_penable_out, 0);
        chk_val("midrst_hreadyout", s_hreadyout_out, 1);
        chk_val("midrst_hresp", s_hresp_out, 0);
        chk_val("midrst_hrdata", s_hrdata_out, 0);
        last_rdata = '0;
        hreset_in = 1'b0;
        step();

        prev_ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            int nw;
            bit se;
            addr = $urandom;
            wr   = 1'($urandom);
            size = 3'($urandom_range(0, 2));
            if (size == 3'd1) addr[0] = 1'b0;
            if (size == 3'd2) addr[1:0] = 2'b00;
            nw = int'($urandom_range(0, 3));
            se = ($urandom_range(0, 4) == 0);
            if (!(prev_ok && $urandom_range(0, 1) == 1)) idle_gap();
            ahb_xfer(addr, wr, size, $urandom, nw, se);
            prev_ok = !s_hresp_out;
            if (n % 50 == 49) noise(4);
        end
        idle_gap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
